// File: rtl/piso_arb_seq.sv
// Round-robin arbiter plus LSB-first serializer for two parallel requesters.
// One word is captured per frame; each bit is held DIV clocks on so.
module piso_arb_seq #(
  parameter int W   = 4,
  parameter int DIV = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0_valid,
  input  logic [W-1:0] req0_data,
  output logic         req0_ready,
  input  logic         req1_valid,
  input  logic [W-1:0] req1_data,
  output logic         req1_ready,
  output logic         so,
  output logic         sof,
  output logic         src,
  output logic         busy,
  output logic         done
);
  localparam int BW = $clog2(W);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DW-1:0]  div_cnt_q, div_cnt_d;
  logic           src_q, src_d;
  logic           last_grant_q, last_grant_d;
  logic           done_q, done_d;

  logic idle, accept, bit_last, div_last;

  assign idle     = (state_q == IDLE);
  assign bit_last = (bit_cnt_q == BW'(W - 1));
  assign div_last = (div_cnt_q == DW'(DIV - 1));

  // last_grant names the previous winner, so the other side wins a tie
  assign req0_ready = idle & ~rst & req0_valid & (~req1_valid | last_grant_q);
  assign req1_ready = idle & ~rst & req1_valid & (~req0_valid | ~last_grant_q);
  assign accept     = req0_ready | req1_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SHIFT;
      SHIFT:   if (bit_last && div_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // datapath next values
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    div_cnt_d    = div_cnt_q;
    src_d        = src_q;
    last_grant_d = last_grant_q;
    done_d       = 1'b0;
    if (idle) begin
      if (accept) begin
        shreg_d      = req1_ready ? req1_data : req0_data;
        src_d        = req1_ready;
        last_grant_d = req1_ready;
        bit_cnt_d    = '0;
        div_cnt_d    = '0;
      end
    end else if (div_last) begin
      div_cnt_d = '0;
      shreg_d   = shreg_q >> 1;
      bit_cnt_d = bit_cnt_q + BW'(1);
      done_d    = bit_last;
    end else begin
      div_cnt_d = div_cnt_q + DW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      div_cnt_q    <= '0;
      src_q        <= 1'b0;
      last_grant_q <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      div_cnt_q    <= div_cnt_d;
      src_q        <= src_d;
      last_grant_q <= last_grant_d;
      done_q       <= done_d;
    end
  end

  // outputs
  always_comb begin
    so   = 1'b0;
    sof  = 1'b0;
    busy = 1'b0;
    if (state_q == SHIFT) begin
      so   = shreg_q[0];
      sof  = (bit_cnt_q == '0);
      busy = 1'b1;
    end
    src  = src_q;
    done = done_q;
  end

endmodule
